z_buffer_ctrl: RTL and testbench
================================

# z_buffer_ctrl

Parametrised z-buffer controller between the rasteriser pixel stream and the shared frame/depth memory port. Each incoming pixel is handled as a read-compare-write transaction: the stored depth at the pixel address is read, compared against the incoming depth using a selectable test, and `{depth, color}` is written back only if the test passes. The block also provides an optional full-buffer clear sweep. It supersedes the fixed 2-bit, always-`<=` z-buffer test logic.

## Interface
Parameters:
- `ADDR_W`, 18, pixel/memory address width
- `DEPTH_W`, 2, depth field width; occupies the MSBs of each memory word
- `COLOR_W`, 14, color field width; `DATA_W = DEPTH_W + COLOR_W` (16 at defaults)
- `NUM_PIX`, 76800, number of pixel words swept by a clear (addresses `0..NUM_PIX-1`)
- `CLEAR_DEPTH`, all ones, depth value written by a clear

Ports:
- `clock` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high
- `iPIX_VALID` in 1: pixel request
- `oPIX_READY` out 1: pixel accepted when `iPIX_VALID & oPIX_READY`
- `iPIX_ADDR` in `ADDR_W`: pixel address
- `iPIX_DEPTH` in `DEPTH_W`: pixel depth (unsigned; smaller is nearer)
- `iPIX_COLOR` in `COLOR_W`: pixel color
- `iMODE` in 2: depth test; 00 LESS, 01 LEQUAL, 10 GREATER, 11 ALWAYS
- `iCLEAR` in 1: clear request (level or pulse)
- `oBUSY` out 1: high in any state other than IDLE, or while a clear is pending
- `oMEM_ADDR` out `ADDR_W`, `oMEM_READ` out 1, `oMEM_WRITE` out 1, `oMEM_DATA` out `DATA_W`: memory request
- `iMEM_WAIT` in 1: memory stall; the request is held unchanged while high
- `iMEM_DATA` in `DATA_W`, `iMEM_VALID` in 1: read return
- `oDISCARD` out 1: one-cycle pulse when a pixel fails the depth test

## Operation
- States: IDLE, READ, WAIT, WRITE, CLEAR.
- IDLE:
  - `oPIX_READY = 1` only in IDLE with no clear pending.
  - A pending or asserted `iCLEAR` has priority over `iPIX_VALID` and enters CLEAR (compiled-in only).
  - On pixel accept, latch addr/depth/color and the mode. Mode `11` goes to WRITE; any other mode goes to READ.
- READ: drive `oMEM_READ = 1` with `oMEM_ADDR = latched addr`. Hold while `iMEM_WAIT`, otherwise go to WAIT.
- WAIT:
  - On `iMEM_VALID`, compare latched depth (unsigned) against `iMEM_DATA[DATA_W-1 -: DEPTH_W]`:
    - LESS: pass if `<`
    - LEQUAL: pass if `<=`
    - GREATER: pass if `>`
  - Pass goes to WRITE. Fail pulses `oDISCARD` and goes to IDLE.
  - `iMEM_VALID` outside WAIT is ignored.
- WRITE: drive `oMEM_WRITE = 1` with `oMEM_DATA = {depth, color}`. Hold while `iMEM_WAIT`, otherwise go to IDLE.
- CLEAR:
  - Write `{CLEAR_DEPTH, COLOR_W'b0}` to the address counter, starting at 0.
  - The counter increments on each cycle with `!iMEM_WAIT`.
  - After the write at `NUM_PIX-1` is accepted, return to IDLE and reset the counter to 0.
- `iCLEAR` seen in READ/WAIT/WRITE sets a pending flag. The in-flight pixel completes first, then the clear starts; the flag is cleared on CLEAR entry. `iCLEAR` during CLEAR is ignored and does not restart the sweep.
- `oMEM_READ` and `oMEM_WRITE` are never both high.
- All memory outputs are registered. Outside READ/WRITE/CLEAR, `oMEM_READ` and `oMEM_WRITE` are low.

## Timing
- Reset values: state IDLE, `oPIX_READY = 1`, `oBUSY = 0`, `oMEM_READ = 0`, `oMEM_WRITE = 0`, `oMEM_ADDR = 0`, `oMEM_DATA = 0`, `oDISCARD = 0`, pending flag 0, clear counter 0.
- Reset mid-operation aborts the transaction or sweep immediately; no partial write is issued after reset.
- Compare modes with 1-cycle memory and no wait:
  - accept at cycle 0
  - `oMEM_READ` during cycle 1
  - `iMEM_VALID` at cycle 2
  - `oMEM_WRITE` during cycle 3
  - `oPIX_READY` high again at cycle 4
  - A failing pixel gives `oDISCARD` at cycle 3 and ready at cycle 3.
- ALWAYS mode: accept at cycle 0, write at cycle 1, ready at cycle 2.
- Clear sweep takes exactly `NUM_PIX` cycles plus the number of `iMEM_WAIT` cycles.
- Each `iMEM_WAIT` cycle adds exactly one cycle to the affected state.

## Configuration
- `Z_BUFFER_CLEAR_EN` defined: CLEAR state, clear counter and pending flag are built; `iCLEAR` behaves as specified above.
- Not defined: `iCLEAR` is ignored and CLEAR is unreachable. `oBUSY` reflects only pixel transactions.

## Test plan
- Stored word `16'hC000`, pixel depth 2, color `14'h0F00`, mode LESS → read of the pixel addr, then write of `16'h8F00` at the same addr, ready at cycle 4.
- Same stimulus with stored depth 2 → LESS: `oDISCARD` pulse, no write. LEQUAL: write of `16'h8F00`.
- Mode ALWAYS, pixel depth 3 over stored depth 0 → no read issued; write at cycle 1 of `{2'b11, color}`.
- With `Z_BUFFER_CLEAR_EN` and `NUM_PIX = 8`, pulse `iCLEAR` → 8 consecutive writes of `16'hC000` to addresses 0..7, then IDLE. `iCLEAR` asserted during WAIT → the in-flight pixel completes first, then the sweep starts.
- Hold `iMEM_WAIT` high for 3 cycles during READ and during WRITE → address and data are stable throughout; total latency grows by 6.
- Assert `reset` during CLEAR at address 5 → all outputs take reset values asynchronously; after release, the first accepted pixel behaves normally and no clear resumes.

Source files
------------

// File: rtl/z_buffer_ctrl_if.sv
// Pixel-stream and memory-port bundle for z_buffer_ctrl.
// slave is the controller's view, master is the rasteriser/memory view.
interface z_buffer_ctrl_if #(
    parameter int ADDR_W  = 18,
    parameter int DEPTH_W = 2,
    parameter int COLOR_W = 14
);
    localparam int DATA_W = DEPTH_W + COLOR_W;

    logic               iPIX_VALID;
    logic               oPIX_READY;
    logic [ADDR_W-1:0]  iPIX_ADDR;
    logic [DEPTH_W-1:0] iPIX_DEPTH;
    logic [COLOR_W-1:0] iPIX_COLOR;
    logic [1:0]         iMODE;
    logic               iCLEAR;
    logic               oBUSY;
    logic [ADDR_W-1:0]  oMEM_ADDR;
    logic               oMEM_READ;
    logic               oMEM_WRITE;
    logic [DATA_W-1:0]  oMEM_DATA;
    logic               iMEM_WAIT;
    logic [DATA_W-1:0]  iMEM_DATA;
    logic               iMEM_VALID;
    logic               oDISCARD;

    modport slave (
        input  iPIX_VALID, iPIX_ADDR, iPIX_DEPTH, iPIX_COLOR, iMODE, iCLEAR,
        input  iMEM_WAIT, iMEM_DATA, iMEM_VALID,
        output oPIX_READY, oBUSY, oMEM_ADDR, oMEM_READ, oMEM_WRITE, oMEM_DATA, oDISCARD
    );

    modport master (
        output iPIX_VALID, iPIX_ADDR, iPIX_DEPTH, iPIX_COLOR, iMODE, iCLEAR,
        output iMEM_WAIT, iMEM_DATA, iMEM_VALID,
        input  oPIX_READY, oBUSY, oMEM_ADDR, oMEM_READ, oMEM_WRITE, oMEM_DATA, oDISCARD
    );
endinterface

// File: rtl/z_buffer_ctrl.sv
// Z-buffer controller: read-compare-write per pixel against shared memory.
// Optional full-buffer clear sweep is built when Z_BUFFER_CLEAR_EN is defined.
module z_buffer_ctrl #(
    parameter int                 ADDR_W      = 18,
    parameter int                 DEPTH_W     = 2,
    parameter int                 COLOR_W     = 14,
    parameter int                 NUM_PIX     = 76800,
    parameter logic [DEPTH_W-1:0] CLEAR_DEPTH = '1
) (
    input  logic          clock,
    input  logic          reset,
    z_buffer_ctrl_if.slave bus
);
    localparam int DATA_W = DEPTH_W + COLOR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);

    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, CLEAR} state_t;

    state_t             stateReg;
    logic [DEPTH_W-1:0] depthReg;
    logic [COLOR_W-1:0] colorReg;
    logic [1:0]         modeReg;
    logic [ADDR_W-1:0]  memAddrReg;
    logic [DATA_W-1:0]  memDataReg;
    logic               memReadReg;
    logic               memWriteReg;
    logic               discardReg;
    logic               depthPass;
    logic [DEPTH_W-1:0] storedDepth;

    // Only the depth field of the returned word takes part in the test.
    assign storedDepth = bus.iMEM_DATA[DATA_W-1 -: DEPTH_W];
    logic [COLOR_W-1:0] unusedColor;
    assign unusedColor = bus.iMEM_DATA[COLOR_W-1:0];

    // Depth test on the latched pixel against the stored depth.
    always_comb begin
        depthPass = 1'b1;
        case (modeReg)
            2'b00:   depthPass = depthReg <  storedDepth;
            2'b01:   depthPass = depthReg <= storedDepth;
            2'b10:   depthPass = depthReg >  storedDepth;
            default: depthPass = 1'b1;
        endcase
    end

`ifdef Z_BUFFER_CLEAR_EN
    logic              pendingReg;
    logic [ADDR_W-1:0] clearCntReg;
    logic              startClear;

    assign startClear     = pendingReg | bus.iCLEAR;
    // A clear request owns IDLE, so no pixel may be handshaked alongside it.
    assign bus.oPIX_READY = (stateReg == IDLE) & ~pendingReg & ~bus.iCLEAR;
    assign bus.oBUSY      = (stateReg != IDLE) | pendingReg | bus.iCLEAR;
`else
    assign bus.oPIX_READY = (stateReg == IDLE);
    assign bus.oBUSY      = (stateReg != IDLE);
    logic unusedClearCfg;
    assign unusedClearCfg = bus.iCLEAR ^ (^CLEAR_DEPTH) ^ (^LAST_ADDR);
`endif

    assign bus.oMEM_ADDR  = memAddrReg;
    assign bus.oMEM_DATA  = memDataReg;
    assign bus.oMEM_READ  = memReadReg;
    assign bus.oMEM_WRITE = memWriteReg;
    assign bus.oDISCARD   = discardReg;

    // Transaction FSM with registered memory-side outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stateReg    <= IDLE;
            depthReg    <= '0;
            colorReg    <= '0;
            modeReg     <= '0;
            memAddrReg  <= '0;
            memDataReg  <= '0;
            memReadReg  <= 1'b0;
            memWriteReg <= 1'b0;
            discardReg  <= 1'b0;
`ifdef Z_BUFFER_CLEAR_EN
            pendingReg  <= 1'b0;
            clearCntReg <= '0;
`endif
        end else begin
            discardReg <= 1'b0;
`ifdef Z_BUFFER_CLEAR_EN
            // Remember a clear that arrives while a pixel is in flight.
            if (bus.iCLEAR && (stateReg == READ || stateReg == WAIT || stateReg == WRITE))
                pendingReg <= 1'b1;
`endif
            case (stateReg)
                IDLE: begin
`ifdef Z_BUFFER_CLEAR_EN
                    if (startClear) begin
                        stateReg    <= CLEAR;
                        pendingReg  <= 1'b0;
                        clearCntReg <= '0;
                        memAddrReg  <= '0;
                        memDataReg  <= {CLEAR_DEPTH, {COLOR_W{1'b0}}};
                        memWriteReg <= 1'b1;
                    end else
`endif
                    if (bus.iPIX_VALID) begin
                        depthReg   <= bus.iPIX_DEPTH;
                        colorReg   <= bus.iPIX_COLOR;
                        modeReg    <= bus.iMODE;
                        memAddrReg <= bus.iPIX_ADDR;
                        if (bus.iMODE == 2'b11) begin
                            stateReg    <= WRITE;
                            memDataReg  <= {bus.iPIX_DEPTH, bus.iPIX_COLOR};
                            memWriteReg <= 1'b1;
                        end else begin
                            stateReg   <= READ;
                            memReadReg <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (!bus.iMEM_WAIT) begin
                        memReadReg <= 1'b0;
                        stateReg   <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.iMEM_VALID) begin
                        if (depthPass) begin
                            stateReg    <= WRITE;
                            memDataReg  <= {depthReg, colorReg};
                            memWriteReg <= 1'b1;
                        end else begin
                            discardReg <= 1'b1;
                            stateReg   <= IDLE;
                        end
                    end
                end
                WRITE: begin
                    if (!bus.iMEM_WAIT) begin
                        memWriteReg <= 1'b0;
                        stateReg    <= IDLE;
                    end
                end
`ifdef Z_BUFFER_CLEAR_EN
                CLEAR: begin
                    if (!bus.iMEM_WAIT) begin
                        if (clearCntReg == LAST_ADDR) begin
                            memWriteReg <= 1'b0;
                            clearCntReg <= '0;
                            stateReg    <= IDLE;
                        end else begin
                            clearCntReg <= clearCntReg + 1'b1;
                            memAddrReg  <= clearCntReg + 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    memReadReg  <= 1'b0;
                    memWriteReg <= 1'b0;
                    stateReg    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_z_buffer_ctrl.sv
// Scoreboard bench for z_buffer_ctrl: stimulus pushes expected memory
// events (kind, address, data, cycle); a monitor pops them as they occur.
module tb_z_buffer_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    z_buffer_ctrl_if #(.ADDR_W(18), .DEPTH_W(2), .COLOR_W(14)) bus ();

    z_buffer_ctrl #(.NUM_PIX(8)) dut (.clock(clock), .reset(reset), .bus(bus));

    typedef struct {
        int          kind;   // 0 read, 1 write, 2 discard
        logic [17:0] addr;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t        expQ[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [15:0] storedWord = 16'h0;
    int          rdStall = 0;
    int          wrStall = 0;

    always @(posedge clock) cyc = cyc + 1;

    task automatic check(input string nm, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic matchEvent(input int k);
        exp_t e;
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event kind=%0d addr=%0h data=%0h cyc=%0d required=none",
                     k, bus.oMEM_ADDR, bus.oMEM_DATA, cyc);
        end else begin
            e = expQ.pop_front();
            if (e.kind != k || e.cyc != cyc ||
                (k != 2 && bus.oMEM_ADDR !== e.addr) ||
                (k == 1 && bus.oMEM_DATA !== e.data)) begin
                errors++;
                $display("FAIL event actual kind=%0d addr=%0h data=%0h cyc=%0d required kind=%0d addr=%0h data=%0h cyc=%0d",
                         k, bus.oMEM_ADDR, bus.oMEM_DATA, cyc, e.kind, e.addr, e.data, e.cyc);
            end else begin
                $display("txn kind=%0d addr=%0h data=%0h cyc=%0d", k, bus.oMEM_ADDR, bus.oMEM_DATA, cyc);
            end
        end
    endtask

    // Memory model: one-cycle read return, programmable stalls.
    logic rdFire = 1'b0;
    initial begin
        bus.iMEM_WAIT  = 1'b0;
        bus.iMEM_VALID = 1'b0;
        bus.iMEM_DATA  = '0;
        forever begin
            @(negedge clock);
            rdFire = bus.oMEM_READ && !bus.iMEM_WAIT && !reset;
            @(posedge clock);
            #1;
            bus.iMEM_VALID = rdFire;
            bus.iMEM_DATA  = rdFire ? storedWord : 16'h0;
            if (bus.oMEM_READ && rdStall > 0) begin
                bus.iMEM_WAIT = 1'b1;
                rdStall--;
            end else if (bus.oMEM_WRITE && wrStall > 0) begin
                bus.iMEM_WAIT = 1'b1;
                wrStall--;
            end else begin
                bus.iMEM_WAIT = 1'b0;
            end
        end
    end

    // Monitor: request stability under stall, exclusivity, scoreboard pops.
    logic        stalledPrev = 1'b0;
    logic [17:0] heldAddr;
    logic [15:0] heldData;
    logic        heldRd, heldWr;
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                stalledPrev = 1'b0;
            end else begin
                if (stalledPrev) begin
                    checks++;
                    if (bus.oMEM_ADDR !== heldAddr || bus.oMEM_DATA !== heldData ||
                        bus.oMEM_READ !== heldRd || bus.oMEM_WRITE !== heldWr) begin
                        errors++;
                        $display("FAIL stall_hold actual addr=%0h data=%0h rd=%b wr=%b required addr=%0h data=%0h rd=%b wr=%b",
                                 bus.oMEM_ADDR, bus.oMEM_DATA, bus.oMEM_READ, bus.oMEM_WRITE,
                                 heldAddr, heldData, heldRd, heldWr);
                    end
                end
                if (bus.oMEM_READ && bus.oMEM_WRITE) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_wr_exclusive actual=11 required=not both");
                end
                stalledPrev = (bus.oMEM_READ || bus.oMEM_WRITE) && bus.iMEM_WAIT;
                heldAddr = bus.oMEM_ADDR;
                heldData = bus.oMEM_DATA;
                heldRd   = bus.oMEM_READ;
                heldWr   = bus.oMEM_WRITE;
                if (bus.oMEM_READ && !bus.iMEM_WAIT)       matchEvent(0);
                else if (bus.oMEM_WRITE && !bus.iMEM_WAIT) matchEvent(1);
                if (bus.oDISCARD)                          matchEvent(2);
            end
        end
    end

    // outcome: 0 read+write, 1 read+discard, 2 write only
    task automatic issue(input logic [17:0] a, input logic [1:0] d, input logic [13:0] c,
                         input logic [1:0] m, input logic [15:0] stored, input int rs,
                         input int ws, input int outcome, input logic [15:0] expData,
                         output int c0);
        storedWord     = stored;
        rdStall        = rs;
        wrStall        = ws;
        bus.iPIX_ADDR  = a;
        bus.iPIX_DEPTH = d;
        bus.iPIX_COLOR = c;
        bus.iMODE      = m;
        bus.iPIX_VALID = 1'b1;
        c0 = cyc;
        check("ready_at_accept", bus.oPIX_READY, 1);
        if (outcome == 0) begin
            expQ.push_back('{0, a, 16'h0, c0 + 1 + rs});
            expQ.push_back('{1, a, expData, c0 + 3 + rs + ws});
        end else if (outcome == 1) begin
            expQ.push_back('{0, a, 16'h0, c0 + 1 + rs});
            expQ.push_back('{2, a, 16'h0, c0 + 3 + rs});
        end else begin
            expQ.push_back('{1, a, expData, c0 + 1 + ws});
        end
        @(posedge clock); #1;
        bus.iPIX_VALID = 1'b0;
    endtask

    task automatic waitReady(input int c0, input int expLat, input string nm);
        bit ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (bus.oPIX_READY) begin
                ok = 1'b1;
                break;
            end
            @(posedge clock); #1;
        end
        check(nm, ok ? longint'(cyc - c0) : -1, expLat);
    endtask

    task automatic pixel(input logic [17:0] a, input logic [1:0] d, input logic [13:0] c,
                         input logic [1:0] m, input logic [15:0] stored, input int rs,
                         input int ws, input int outcome, input logic [15:0] expData,
                         input int expLat, input string nm);
        int c0;
        issue(a, d, c, m, stored, rs, ws, outcome, expData, c0);
        waitReady(c0, expLat, nm);
        @(posedge clock); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        bit seen;
        bus.iPIX_VALID = 1'b0;
        bus.iPIX_ADDR  = '0;
        bus.iPIX_DEPTH = '0;
        bus.iPIX_COLOR = '0;
        bus.iMODE      = '0;
        bus.iCLEAR     = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_ready", bus.oPIX_READY, 1);
        check("rst_busy",  bus.oBUSY, 0);
        check("rst_rdwr",  {bus.oMEM_READ, bus.oMEM_WRITE, bus.oDISCARD}, 0);
        check("rst_addr",  bus.oMEM_ADDR, 0);
        check("rst_data",  bus.oMEM_DATA, 0);
        reset = 1'b0;
        @(posedge clock); #1;

        pixel(18'h00123, 2'd2, 14'h0F00, 2'b00, 16'hC000, 0, 0, 0, 16'h8F00, 4, "less_pass_lat");
        pixel(18'h00123, 2'd2, 14'h0F00, 2'b00, 16'h8000, 0, 0, 1, 16'h0,    3, "less_fail_lat");
        pixel(18'h00200, 2'd2, 14'h0F00, 2'b01, 16'h8000, 0, 0, 0, 16'h8F00, 4, "lequal_eq_lat");
        pixel(18'h00201, 2'd2, 14'h0F00, 2'b10, 16'h4000, 0, 0, 0, 16'h8F00, 4, "greater_pass_lat");
        pixel(18'h00202, 2'd2, 14'h0F00, 2'b10, 16'hC000, 0, 0, 1, 16'h0,    3, "greater_fail_lat");
        pixel(18'h00300, 2'd3, 14'h1234, 2'b11, 16'h0000, 0, 0, 2, 16'hD234, 2, "always_lat");
        pixel(18'h3FFFF, 2'd0, 14'h3FFF, 2'b01, 16'h0000, 0, 0, 0, 16'h3FFF, 4, "lequal_zero_lat");
        pixel(18'h3FFFF, 2'd0, 14'h3FFF, 2'b00, 16'h0000, 0, 0, 1, 16'h0,    3, "less_zero_lat");
        pixel(18'h00010, 2'd3, 14'h0001, 2'b10, 16'hFFFF, 0, 0, 1, 16'h0,    3, "greater_max_lat");
        pixel(18'h00444, 2'd2, 14'h0F00, 2'b00, 16'hC000, 3, 3, 0, 16'h8F00, 10, "stall_lat");

`ifdef Z_BUFFER_CLEAR_EN
        bus.iCLEAR = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 8; i++) expQ.push_back('{1, 18'(i), 16'hC000, c0 + 1 + i});
        @(posedge clock); #1;
        bus.iCLEAR = 1'b0;
        check("clear_busy", bus.oBUSY, 1);
        waitReady(c0, 9, "clear_lat");
        @(posedge clock); #1;

        issue(18'h00055, 2'd1, 14'h0ABC, 2'b00, 16'hC000, 0, 0, 0, 16'h4ABC, c0);
        @(posedge clock); #1;
        bus.iCLEAR = 1'b1;
        @(posedge clock); #1;
        bus.iCLEAR = 1'b0;
        for (int i = 0; i < 8; i++) expQ.push_back('{1, 18'(i), 16'hC000, c0 + 5 + i});
        @(posedge clock); #1;
        check("pending_busy",  bus.oBUSY, 1);
        check("pending_ready", bus.oPIX_READY, 0);
        waitReady(c0, 13, "clear_after_pixel_lat");
        @(posedge clock); #1;

        bus.iCLEAR = 1'b1;
        for (int i = 0; i < 5; i++) expQ.push_back('{1, 18'(i), 16'hC000, cyc + 1 + i});
        @(posedge clock); #1;
        bus.iCLEAR = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (bus.oMEM_WRITE && bus.oMEM_ADDR == 18'd5) begin
                seen = 1'b1;
                break;
            end
            @(posedge clock); #1;
        end
        check("clear_reach_addr5", seen, 1);
`else
        bus.iCLEAR = 1'b1;
        #1;
        check("noclear_ready", bus.oPIX_READY, 1);
        @(posedge clock); #1;
        bus.iCLEAR = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("noclear_busy", bus.oBUSY, 0);

        issue(18'h00777, 2'd1, 14'h0055, 2'b00, 16'hC000, 0, 20, 0, 16'h4055, c0);
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (bus.oMEM_WRITE) begin
                seen = 1'b1;
                break;
            end
            @(posedge clock); #1;
        end
        check("reach_write", seen, 1);
        @(negedge clock); #1;
`endif
        reset = 1'b1;
        #1;
        check("async_rst_rdwr", {bus.oMEM_READ, bus.oMEM_WRITE, bus.oDISCARD}, 0);
        check("async_rst_addr", bus.oMEM_ADDR, 0);
        check("async_rst_data", bus.oMEM_DATA, 0);
        check("async_rst_busy", bus.oBUSY, 0);
        expQ.delete();
        wrStall = 0;
        rdStall = 0;
        @(posedge clock);
        @(negedge clock); #1;
        reset = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        check("post_rst_busy", bus.oBUSY, 0);
        pixel(18'h00066, 2'd2, 14'h0F00, 2'b00, 16'hC000, 0, 0, 0, 16'h8F00, 4, "post_rst_lat");
        repeat (4) @(posedge clock);
        #1;
        check("queue_drained", expQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
